// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Purpose : bundles the request bus from the EX/MEM latch, the data-memory
//           port and the results returned to the pipeline for mem_access_unit.
// Ports   : no clock/reset; the bus signals are
//   request   i_valid, i_mem_read, i_mem_write, i_size, i_unsigned,
//             i_addr, i_wdata
//   memory    i_mem_rdata (in), o_mem_enable, o_mem_read, o_mem_write,
//             o_mem_addr, o_mem_wdata (out)
//   pipeline  o_stall, o_load_data, o_done, o_misaligned (out)
// Modports: slave  = the MEM-stage controller
//           master = whatever drives requests and models memory
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int REG_SIZE  = 5
);
    // Handshake: a request is i_valid=1 with its fields stable; the
    // requester must hold every request field unchanged while o_stall=1
    // and may change them at the first clock edge where o_stall=0.
    logic                 i_valid;
    logic                 i_mem_read;
    logic                 i_mem_write;
    logic [1:0]           i_size;
    logic                 i_unsigned;
    logic [ADDR_SIZE-1:0] i_addr;
    logic [DATA_SIZE-1:0] i_wdata;
    logic [DATA_SIZE-1:0] i_mem_rdata;
    logic                 o_mem_enable;
    logic                 o_mem_read;
    logic                 o_mem_write;
    logic [REG_SIZE-1:0]  o_mem_addr;
    logic [DATA_SIZE-1:0] o_mem_wdata;
    logic                 o_stall;
    logic [DATA_SIZE-1:0] o_load_data;
    logic                 o_done;
    logic                 o_misaligned;

    modport slave (
        input  i_valid, i_mem_read, i_mem_write, i_size, i_unsigned,
               i_addr, i_wdata, i_mem_rdata,
        output o_mem_enable, o_mem_read, o_mem_write, o_mem_addr,
               o_mem_wdata, o_stall, o_load_data, o_done, o_misaligned
    );

    modport master (
        output i_valid, i_mem_read, i_mem_write, i_size, i_unsigned,
               i_addr, i_wdata, i_mem_rdata,
        input  o_mem_enable, o_mem_read, o_mem_write, o_mem_addr,
               o_mem_wdata, o_stall, o_load_data, o_done, o_misaligned
    );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Purpose : MEM-stage controller. Turns byte-addressed LB/LBU/LH/LHU/LW and
//           SB/SH/SW requests into word-index accesses on a 1-cycle-latency
//           synchronous data memory. Loads extract and extend the lane;
//           SB/SH are done as read-modify-write. o_stall holds the pipeline
//           while a multi-cycle access is in flight.
// Ports   : i_clock  rising-edge clock
//           i_reset  asynchronous active-low reset
//           bus      mem_access_unit_if.slave (request, memory, results)
//           o_state  current FSM state (debug visibility)
// Config  : define MEM_ALIGN_CHECK_EN to squash misaligned halfword/word
//           accesses and pulse o_misaligned; otherwise low address bits
//           are ignored for those sizes and o_misaligned stays 0.
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 32,
    parameter int REG_SIZE  = 5
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    mem_access_unit_if.slave      bus,
    output logic [1:0]            o_state
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_MERGE = 2'd2,
        RMW_WRITE = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [DATA_SIZE-1:0] load_data_q, merge_q;
    logic                 done_q, misaligned_q;

    logic                 is_byte, is_half, is_sub, misaligned;
    logic                 want_read, want_write;
    logic                 done_next, misaligned_next;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [DATA_SIZE-1:0] extended, merged;

    // Upper address bits only select outside this 32-word memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.i_addr[ADDR_SIZE-1:REG_SIZE+2];

    // Request decode. Size 10 falls through to word.
    always_comb begin
        is_byte = (bus.i_size == 2'b00);
        is_half = (bus.i_size == 2'b01);
        is_sub  = is_byte | is_half;
`ifdef MEM_ALIGN_CHECK_EN
        misaligned = (bus.i_mem_read | bus.i_mem_write) &
                     ((is_half & bus.i_addr[0]) |
                      (!is_sub & (bus.i_addr[1:0] != 2'b00)));
`else
        misaligned = 1'b0;
`endif
        // Store wins when both strobes are set.
        want_write = bus.i_valid & bus.i_mem_write & !misaligned;
        want_read  = bus.i_valid & bus.i_mem_read & !bus.i_mem_write & !misaligned;
    end

    // Load lane extraction and sub-word merge (little-endian lanes).
    always_comb begin
        byte_sel = bus.i_mem_rdata[{bus.i_addr[1:0], 3'b000} +: 8];
        half_sel = bus.i_addr[1] ? bus.i_mem_rdata[31:16] : bus.i_mem_rdata[15:0];
        if (is_byte)
            extended = {{24{!bus.i_unsigned & byte_sel[7]}}, byte_sel};
        else if (is_half)
            extended = {{16{!bus.i_unsigned & half_sel[15]}}, half_sel};
        else
            extended = bus.i_mem_rdata;

        merged = bus.i_mem_rdata;
        if (is_byte)
            merged[{bus.i_addr[1:0], 3'b000} +: 8] = bus.i_wdata[7:0];
        else if (bus.i_addr[1])
            merged[31:16] = bus.i_wdata[15:0];
        else
            merged[15:0] = bus.i_wdata[15:0];
    end

    // FSM: state register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_next;
    end

    // FSM: next state and completion flags
    always_comb begin
        state_next      = state;
        done_next       = 1'b0;
        misaligned_next = 1'b0;
        case (state)
            IDLE: begin
                if (want_write && is_sub)
                    state_next = RMW_MERGE;
                else if (want_read)
                    state_next = LOAD_WAIT;
                // Word store, no-op request and squashed access all finish now.
                done_next       = bus.i_valid & !want_read & !(want_write & is_sub);
                misaligned_next = bus.i_valid & misaligned;
            end
            LOAD_WAIT: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            RMW_MERGE: state_next = RMW_WRITE;
            RMW_WRITE: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM: memory strobes and stall
    always_comb begin
        bus.o_mem_enable = 1'b0;
        bus.o_mem_read   = 1'b0;
        bus.o_mem_write  = 1'b0;
        bus.o_mem_wdata  = bus.i_wdata;
        bus.o_stall      = 1'b0;
        case (state)
            IDLE: begin
                if (want_write && !is_sub) begin
                    bus.o_mem_enable = 1'b1;
                    bus.o_mem_write  = 1'b1;
                end else if (want_write || want_read) begin
                    bus.o_mem_enable = 1'b1;
                    bus.o_mem_read   = 1'b1;
                    bus.o_stall      = 1'b1;
                end
            end
            RMW_MERGE: bus.o_stall = 1'b1;
            RMW_WRITE: begin
                bus.o_mem_enable = 1'b1;
                bus.o_mem_write  = 1'b1;
                bus.o_mem_wdata  = merge_q;
            end
            default: ;
        endcase
        // Requests may already be presented during reset; keep memory quiet.
        if (!i_reset) begin
            bus.o_mem_enable = 1'b0;
            bus.o_mem_read   = 1'b0;
            bus.o_mem_write  = 1'b0;
            bus.o_stall      = 1'b0;
        end
    end

    // Result and merge registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            load_data_q  <= '0;
            merge_q      <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            done_q       <= done_next;
            misaligned_q <= misaligned_next;
            if (state == LOAD_WAIT) load_data_q <= extended;
            if (state == RMW_MERGE) merge_q     <= merged;
        end
    end

    // Address is combinational: the request is held stable under stall.
    assign bus.o_mem_addr  = bus.i_addr[REG_SIZE+1:2];
    assign bus.o_load_data = load_data_q;
    assign bus.o_done      = done_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign bus.o_misaligned = misaligned_q;
`else
    assign bus.o_misaligned = 1'b0;
`endif
    assign o_state = state;
endmodule
